// File: rtl/fetch_decode_pipe_pkg.sv
// Shared definitions for the 16-bit core front end. The execute and writeback
// decode checks use the same opcode, subcode and state constants.
package fetch_decode_pipe_pkg;

    localparam int PC_W  = 16;
    localparam int INS_W = 16;

    // Opcode field, ins[15:12]
    localparam logic [3:0] OP_SUB  = 4'h0;
    localparam logic [3:0] OP_MOVL = 4'h8;
    localparam logic [3:0] OP_MOVH = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_MEM  = 4'hF;

    // Subcode field, ins[7:4], for the jmp opcode
    localparam logic [3:0] SUB_JZ  = 4'h0;
    localparam logic [3:0] SUB_JNZ = 4'h1;
    localparam logic [3:0] SUB_JS  = 4'h2;
    localparam logic [3:0] SUB_JNS = 4'h3;

    // Subcode field, ins[7:4], for the mem opcode
    localparam logic [3:0] SUB_LD  = 4'h0;
    localparam logic [3:0] SUB_ST  = 4'h1;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Internal visibility for checkers and debug
    typedef struct packed {
        state_t state;
        logic   f_valid;
        logic   hold_valid;
    } dbg_t;

    // Eleven decode flags, opcode flags first
    typedef struct packed {
        logic is_sub;
        logic is_movl;
        logic is_movh;
        logic is_jmp;
        logic is_mem;
        logic is_jz;
        logic is_jnz;
        logic is_js;
        logic is_jns;
        logic is_ld;
        logic is_st;
    } dec_flags_t;

endpackage

// File: rtl/fetch_decode_pipe_if.sv
// Bus between the front end, the instruction memory and the execute stage.
// d_valid qualifies every decode output; execute takes the decode slot in any
// cycle with d_valid=1, stall=0 and flush=0. There is no ready signal: the
// core-wide stall is the single back-pressure term and holds the slot intact.
// imem_rdata answers imem_raddr exactly one cycle later.
interface fetch_decode_pipe_if;
    import fetch_decode_pipe_pkg::*;

    logic [PC_W-1:0]  imem_raddr;
    logic [INS_W-1:0] imem_rdata;
    logic [PC_W-1:0]  f_pc;
    logic             d_valid;
    logic [PC_W-1:0]  d_pc;
    logic [INS_W-1:0] d_ins;
    logic             d_isSub;
    logic             d_isMovl;
    logic             d_isMovh;
    logic             d_isJmp;
    logic             d_isMem;
    logic             d_isJz;
    logic             d_isJnz;
    logic             d_isJs;
    logic             d_isJns;
    logic             d_isLd;
    logic             d_isSt;
    logic [3:0]       reg_raddr0;
    logic [3:0]       reg_raddr1;

    modport master (
        output imem_raddr, f_pc, d_valid, d_pc, d_ins,
        output d_isSub, d_isMovl, d_isMovh, d_isJmp, d_isMem,
        output d_isJz, d_isJnz, d_isJs, d_isJns, d_isLd, d_isSt,
        output reg_raddr0, reg_raddr1,
        input  imem_rdata
    );

    modport slave (
        input  imem_raddr, f_pc, d_valid, d_pc, d_ins,
        input  d_isSub, d_isMovl, d_isMovh, d_isJmp, d_isMem,
        input  d_isJz, d_isJnz, d_isJs, d_isJns, d_isLd, d_isSt,
        input  reg_raddr0, reg_raddr1,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_decode_pipe_ins_decoder.sv
// Purely combinational instruction decoder: flags and register read addresses.
// Any unknown opcode or subcode yields all flags low.
module ins_decoder
    import fetch_decode_pipe_pkg::*;
(
    input  logic [INS_W-1:0] ins,
    output dec_flags_t       flags,
    output logic [3:0]       raddr0,
    output logic [3:0]       raddr1
);

    logic [3:0] opcode;
    logic [3:0] subcode;

    assign opcode  = ins[15:12];
    assign subcode = ins[7:4];

    // Opcode/subcode flags; a subcode flag only ever fires with its opcode flag
    always_comb begin
        flags = '0;
        case (opcode)
            OP_SUB:  flags.is_sub  = 1'b1;
            OP_MOVL: flags.is_movl = 1'b1;
            OP_MOVH: flags.is_movh = 1'b1;
            OP_JMP: begin
                case (subcode)
                    SUB_JZ:  begin flags.is_jmp = 1'b1; flags.is_jz  = 1'b1; end
                    SUB_JNZ: begin flags.is_jmp = 1'b1; flags.is_jnz = 1'b1; end
                    SUB_JS:  begin flags.is_jmp = 1'b1; flags.is_js  = 1'b1; end
                    SUB_JNS: begin flags.is_jmp = 1'b1; flags.is_jns = 1'b1; end
                    default: ;
                endcase
            end
            OP_MEM: begin
                case (subcode)
                    SUB_LD:  begin flags.is_mem = 1'b1; flags.is_ld = 1'b1; end
                    SUB_ST:  begin flags.is_mem = 1'b1; flags.is_st = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // sub reads rb from [7:4]; every other format keeps its second source in [3:0]
    assign raddr0 = ins[11:8];
    assign raddr1 = flags.is_sub ? ins[7:4] : ins[3:0];

endmodule

// File: rtl/fetch_decode_pipe.sv
// Fetch and decode stages of the 16-bit four-stage core. Fetch drives the
// instruction memory; decode presents the word, its PC and the decode flags.
module fetch_decode_pipe
    import fetch_decode_pipe_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_STEP  = 16'h0002
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             halt,
    fetch_decode_pipe_if.master bus,
    output dbg_t             dbg
);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  f_pc_q, f_pc_d;
    logic             f_valid_q, f_valid_d;
    logic             d_valid_q, d_valid_d;
    logic [PC_W-1:0]  d_pc_q, d_pc_d;
    logic             hold_valid_q, hold_valid_d;
    logic [INS_W-1:0] hold_ins_q, hold_ins_d;
    logic             halting;
    logic [INS_W-1:0] d_ins;
    dec_flags_t       flags;

    // During a stall memory re-reads the held f_pc, so the decode word comes
    // from the hold register captured on the first stall cycle
    assign d_ins = hold_valid_q ? hold_ins_q : bus.imem_rdata;

    // Next-state and datapath update: FSM, then stall hold, then flush on top
    always_comb begin
        state_d      = state_q;
        f_pc_d       = f_pc_q;
        f_valid_d    = f_valid_q;
        d_valid_d    = d_valid_q;
        d_pc_d       = d_pc_q;
        hold_valid_d = hold_valid_q;
        hold_ins_d   = hold_ins_q;
        halting      = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d   = ST_RUN;
                f_valid_d = 1'b1;
                d_valid_d = 1'b0;
            end
            ST_RUN: begin
                if (!stall) begin
                    d_pc_d    = f_pc_q;
                    d_valid_d = f_valid_q;
                    f_pc_d    = f_pc_q + PC_STEP;
                end
                if (halt) begin
                    state_d   = ST_HALTED;
                    f_valid_d = 1'b0;
                    halting   = 1'b1;
                end
            end
            ST_HALTED: begin
                f_valid_d = 1'b0;
                halting   = 1'b1;
                if (!stall) begin
                    d_valid_d = 1'b0;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (stall && !hold_valid_q) begin
            hold_ins_d   = bus.imem_rdata;
            hold_valid_d = 1'b1;
        end else if (!stall) begin
            hold_valid_d = 1'b0;
        end

        // Flush beats stall; a pending or active halt still blocks new fetches
        if (flush) begin
            f_pc_d       = redirect_pc;
            d_valid_d    = 1'b0;
            f_valid_d    = !halting;
            hold_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            f_pc_q       <= RESET_PC;
            f_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            d_pc_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_ins_q   <= '0;
        end else begin
            state_q      <= state_d;
            f_pc_q       <= f_pc_d;
            f_valid_q    <= f_valid_d;
            d_valid_q    <= d_valid_d;
            d_pc_q       <= d_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_ins_q   <= hold_ins_d;
        end
    end

    ins_decoder u_dec (
        .ins    (d_ins),
        .flags  (flags),
        .raddr0 (bus.reg_raddr0),
        .raddr1 (bus.reg_raddr1)
    );

    assign bus.imem_raddr = f_pc_q;
    assign bus.f_pc       = f_pc_q;
    assign bus.d_valid    = d_valid_q;
    assign bus.d_pc       = d_pc_q;
    assign bus.d_ins      = d_ins;
    assign bus.d_isSub    = flags.is_sub;
    assign bus.d_isMovl   = flags.is_movl;
    assign bus.d_isMovh   = flags.is_movh;
    assign bus.d_isJmp    = flags.is_jmp;
    assign bus.d_isMem    = flags.is_mem;
    assign bus.d_isJz     = flags.is_jz;
    assign bus.d_isJnz    = flags.is_jnz;
    assign bus.d_isJs     = flags.is_js;
    assign bus.d_isJns    = flags.is_jns;
    assign bus.d_isLd     = flags.is_ld;
    assign bus.d_isSt     = flags.is_st;

    assign dbg = '{state: state_q, f_valid: f_valid_q, hold_valid: hold_valid_q};

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Bench for fetch_decode_pipe: directed walk through reset, decode, stall,
// flush, PC wrap and halt, then randomized stall/flush/reset traffic checked
// against a program-order stream model.
module tb_fetch_decode_pipe;
    import fetch_decode_pipe_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] PC_STEP  = 16'h0002;
    localparam int EXP_W = 51;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
        logic [10:0] flags;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    dbg_t        dbg;

    fetch_decode_pipe_if bus();

    fetch_decode_pipe #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .bus         (bus),
        .dbg         (dbg)
    );

    always #5 clk = ~clk;

    // Instruction memory with a one-cycle registered read
    logic [15:0] mem [0:65535];
    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_raddr];

    logic [10:0] dflags;
    assign dflags = {bus.d_isSub, bus.d_isMovl, bus.d_isMovh, bus.d_isJmp, bus.d_isMem,
                     bus.d_isJz, bus.d_isJnz, bus.d_isJs, bus.d_isJns, bus.d_isLd, bus.d_isSt};

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass = 0;
    int n_consumed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Flag bits: 10 sub, 9 movl, 8 movh, 7 jmp, 6 mem, 5 jz, 4 jnz, 3 js, 2 jns, 1 ld, 0 st
    function automatic logic [10:0] ref_flags(input logic [15:0] ins);
        int op;
        int sc;
        logic [10:0] f;
        op = int'(ins[15:12]);
        sc = int'(ins[7:4]);
        f = '0;
        if (op == 0) f[10] = 1'b1;
        else if (op == 8) f[9] = 1'b1;
        else if (op == 9) f[8] = 1'b1;
        else if (op == 14 && sc <= 3) begin f[7] = 1'b1; f[5 - sc] = 1'b1; end
        else if (op == 15 && sc <= 1) begin f[6] = 1'b1; f[1 - sc] = 1'b1; end
        return f;
    endfunction

    function automatic exp_t ref_entry(input logic [15:0] pc);
        exp_t e;
        int ins;
        ins = int'(mem[pc]);
        e.pc    = pc;
        e.ins   = mem[pc];
        e.flags = ref_flags(mem[pc]);
        e.ra0   = 4'((ins / 256) % 16);
        e.ra1   = (mem[pc][15:12] == 4'h0) ? 4'((ins / 16) % 16) : 4'(ins % 16);
        return e;
    endfunction

    // Program-order stream: consecutive PCs from the last reset/redirect point
    logic [EXP_W-1:0] exp_q[$];
    logic [15:0]      stream_pc;

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(ref_entry(stream_pc));
            stream_pc = stream_pc + PC_STEP;
        end
    endtask

    task automatic restart_stream(input logic [15:0] pc);
        exp_q.delete();
        stream_pc = pc;
        top_up();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic s, input logic f, input logic h,
                         input logic [15:0] rpc);
        rst = r; stall = s; flush = f; halt = h; redirect_pc = rpc;
        if (r) restart_stream(RESET_PC);
        else if (f) restart_stream(rpc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        top_up();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush && !stall && bus.d_valid) begin
            n_consumed++;
            if (exp_q.size() == 0) begin
                check("stream_underrun", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_t'(exp_q.pop_front());
                check("sb_pc", bus.d_pc, e.pc);
                check("sb_ins", bus.d_ins, e.ins);
                check("sb_dec", {dflags, bus.reg_raddr0, bus.reg_raddr1}, {e.flags, e.ra0, e.ra1});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    logic [3:0] op_tab [0:4];
    int cons_start;

    initial begin
        op_tab[0] = 4'h0; op_tab[1] = 4'h8; op_tab[2] = 4'h9; op_tab[3] = 4'hE; op_tab[4] = 4'hF;
        for (int a = 0; a < 65536; a++) begin
            if ($urandom_range(0, 3) == 0) mem[a] = 16'($urandom);
            else mem[a] = {op_tab[$urandom_range(0, 4)], 4'($urandom), 4'($urandom_range(0, 4)), 4'($urandom)};
        end
        mem[16'h0000] = 16'h8410;
        mem[16'h0002] = 16'h9020;
        mem[16'h0004] = 16'hF310;
        mem[16'h0006] = 16'hFFFF;
        mem[16'h0008] = 16'h0123;
        mem[16'h0040] = 16'hE200;

        // Reset values
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(); step();
        check("rst_f_pc", bus.f_pc, RESET_PC);
        check("rst_d_valid", bus.d_valid, 1'b0);
        check("rst_d_pc", bus.d_pc, 16'h0000);
        check("rst_state", dbg.state, ST_BOOT);
        check("rst_f_valid", dbg.f_valid, 1'b0);
        check("rst_hold_valid", dbg.hold_valid, 1'b0);

        // Boot cycle, then first two instructions
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        check("boot_state", dbg.state, ST_RUN);
        check("boot_f_valid", dbg.f_valid, 1'b1);
        check("boot_d_valid", bus.d_valid, 1'b0);
        check("boot_f_pc", bus.f_pc, 16'h0000);
        step();
        check("c2_d_valid", bus.d_valid, 1'b1);
        check("c2_d_pc", bus.d_pc, 16'h0000);
        check("c2_flags_movl", dflags, 11'h200);
        check("c2_raddr", {bus.reg_raddr0, bus.reg_raddr1}, 8'h40);
        check("c2_imem_raddr", bus.imem_raddr, 16'h0002);
        step();
        check("c3_d_pc", bus.d_pc, 16'h0002);
        check("c3_flags_movh", dflags, 11'h100);
        step();
        check("c4_d_pc", bus.d_pc, 16'h0004);
        check("c4_flags_st", dflags, 11'h041);

        // Two-cycle stall: memory now returns 16'hFFFF for the held f_pc
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall_d_pc", bus.d_pc, 16'h0004);
            check("stall_d_ins", bus.d_ins, 16'hF310);
            check("stall_flags", dflags, 11'h041);
            check("stall_raddr", {bus.reg_raddr0, bus.reg_raddr1}, 8'h30);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("release_d_ins", bus.d_ins, 16'hF310);
        step();
        check("after_stall_d_pc", bus.d_pc, 16'h0006);
        check("after_stall_d_ins", bus.d_ins, 16'hFFFF);
        check("invalid_flags", dflags, 11'h000);
        check("invalid_d_valid", bus.d_valid, 1'b1);
        step();
        check("sub_flags", dflags, 11'h400);
        check("sub_raddr", {bus.reg_raddr0, bus.reg_raddr1}, 8'h12);

        // Flush together with stall
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0040);
        step();
        check("flush_d_valid", bus.d_valid, 1'b0);
        check("flush_f_pc", bus.f_pc, 16'h0040);
        check("flush_hold_valid", dbg.hold_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        check("redir_d_pc", bus.d_pc, 16'h0040);
        check("redir_d_valid", bus.d_valid, 1'b1);
        check("redir_flags_jz", dflags, 11'h0A0);

        // PC wrap at 16'hFFFE
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE);
        step();
        check("wrap_f_pc0", bus.f_pc, 16'hFFFE);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        check("wrap_f_pc1", bus.f_pc, 16'h0000);
        check("wrap_d_pc", bus.d_pc, 16'hFFFE);
        step();
        check("wrap_d_pc2", bus.d_pc, 16'h0000);

        // Halt: f_valid drops, then d_valid, and both stay low
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        check("halt_state", dbg.state, ST_HALTED);
        check("halt_f_valid", dbg.f_valid, 1'b0);
        check("halt_last_d_valid", bus.d_valid, 1'b1);
        check("halt_f_pc", bus.f_pc, 16'h0004);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        check("halted_d_valid", bus.d_valid, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("halted_hold_d_valid", bus.d_valid, 1'b0);
            check("halted_hold_f_pc", bus.f_pc, 16'h0004);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        check("rerst_f_pc", bus.f_pc, RESET_PC);
        check("rerst_state", dbg.state, ST_BOOT);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(); step();
        check("resume_d_valid", bus.d_valid, 1'b1);
        check("resume_d_pc", bus.d_pc, RESET_PC);

        // Randomized stall/flush/reset traffic; the monitor checks the stream
        cons_start = n_consumed;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic s;
            logic f;
            logic [15:0] rpc;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 99) < 30);
            f = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0) rpc = 16'hFFF0 + 16'($urandom_range(0, 7) * 2);
            else rpc = 16'($urandom) & 16'hFFFE;
            drive(r, s, f, 1'b0, rpc);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 10; k++) step();
        check("random_throughput", 64'(n_consumed - cons_start >= 1000), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode_pipe.md
Name: fetch_decode_pipe

Overview:
- Front end of the 16-bit four-stage pipelined core: fetch (f) and decode (d).
- Drives the instruction memory read port and the two register-file read addresses.
- Presents d_valid, d_pc, d_ins and the decoded opcode/subcode flags to the execute stage.
- Honours the core-wide stall and flush signals; flush redirects fetch to a target PC supplied by writeback.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset.
- PC_STEP, 16'h0002, byte increment between sequential instructions.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold every f/d register; no new fetch.
- flush  in  1  kill f and d contents; redirect fetch.
- redirect_pc  in  16  next fetch address when flush=1.
- halt  in  1  stop fetching permanently until rst.
- imem_raddr  out  16  instruction read address (= f_pc).
- imem_rdata  in  16  instruction word; registered read, valid exactly 1 cycle after imem_raddr.
- f_pc  out  16  address currently in fetch, used by writeback store-modify check.
- d_valid  out  1  decode holds a live instruction.
- d_pc  out  16  PC of the decode instruction.
- d_ins  out  16  instruction word in decode.
- d_isSub, d_isMovl, d_isMovh, d_isJmp, d_isMem  out  1 each  opcode decode.
- d_isJz, d_isJnz, d_isJs, d_isJns, d_isLd, d_isSt  out  1 each  subcode decode.
- reg_raddr0  out  4  = d_ins[11:8] (ra).
- reg_raddr1  out  4  = d_isSub ? d_ins[7:4] : d_ins[3:0].

Behaviour:
- Reset values:
  - f_pc=RESET_PC; f_valid=0; d_valid=0; d_pc=0.
  - hold_valid=0; hold_ins=0; state=BOOT.
- FSM:
  - BOOT: one cycle; f_valid<=1; go to RUN.
  - RUN: normal operation; halt=1 goes to HALTED.
  - HALTED: f_valid<=0; f_pc frozen; only rst exits.
- Fetch in RUN:
  - imem_raddr=f_pc, combinational.
  - Each non-stall cycle: d_pc<=f_pc; d_valid<=f_valid; f_pc<=f_pc+PC_STEP, modulo 2^16 (16'hFFFE+2 wraps to 0).
- Decode:
  - d_ins = hold_valid ? hold_ins : imem_rdata.
  - All flags are combinational from d_ins:
    - opcode [15:12]: 0 sub, 8 movl, 9 movh, E jmp, F mem.
    - jmp subcode [7:4]: 0 jz, 1 jnz, 2 js, 3 jns.
    - mem subcode [7:4]: 0 ld, 1 st.
    - A subcode flag asserts only when its opcode flag is also set.
  - Invalid encodings produce all flags 0 with d_valid unchanged; writeback halts on them.
- Stall:
  - All registers hold.
  - On the first stall cycle, with hold_valid=0: hold_ins<=imem_rdata; hold_valid<=1. This is required because imem_rdata will be re-read from the held f_pc, i.e. the wrong word.
  - reg_raddr0/1 stay constant throughout the stall, so execute's register data remains correct.
  - On the first non-stall cycle after a stall: d_ins still comes from hold; hold_valid<=0 at that edge.
- Flush (priority over stall):
  - f_pc<=redirect_pc; d_valid<=0; f_valid<=1 (unless HALTED); hold_valid<=0.
  - The first instruction from redirect_pc reaches decode 1 cycle later, with d_valid=1.
- Simultaneous events:
  - halt and flush together: halt wins; f_valid<=0, but f_pc still takes redirect_pc.
  - rst beats everything, including mid-stall and mid-flush.
- Latency:
  - Address issue to d_valid: 1 cycle.
  - Decode to execute: 1 register boundary, owned by execute.

Decomposition:
- Shared package, shared with execute/writeback decode checks:
  - opcode constants OP_SUB=0, OP_MOVL=8, OP_MOVH=9, OP_JMP=4'hE, OP_MEM=4'hF.
  - subcode constants.
  - state encoding BOOT/RUN/HALTED.
  - PC width constant 16.
- One natural sub-module: ins_decoder, purely combinational, mapping d_ins to the eleven flags and the two register addresses.

Test Plan:
- Reset then run, imem returns 16'h8410 at addr 0 and 16'h9020 at addr 2 → cycle 2: d_valid=1, d_pc=0, d_isMovl=1, reg_raddr1=0; cycle 3: d_pc=2, d_isMovh=1.
- Sub 16'h0123 in decode → d_isSub=1, reg_raddr0=1, reg_raddr1=2.
- Stall for 2 cycles while d_pc=4 holds 16'hF310 and imem_rdata changes to 16'hFFFF → d_ins stays 16'hF310 with d_isSt=1 throughout; after release, d_pc=6 follows.
- flush=1, redirect_pc=16'h0040 while stall=1 → next cycle d_valid=0, f_pc=16'h0040; following cycle d_pc=16'h0040, d_valid=1.
- f_pc=16'hFFFE with no stall → next f_pc=16'h0000.
- halt asserted → f_valid and then d_valid drop to 0 and stay 0; rst pulse → f_pc=RESET_PC and fetch resumes.
